// File: rtl/trivium_pkg.sv
// Shared constants and FSM state type for the Trivium keystream sequencer.
package trivium_pkg;

    localparam int KEY_W           = 80;
    localparam int IV_W            = 80;
    localparam int STATE_W         = 288;
    localparam int INIT_CYCLES_DEF = 1152;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WARMUP,
        ST_GEN,
        ST_HOLD,
        ST_DONE
    } ctrl_state_t;

endpackage

// File: rtl/trivium_word_packer.sv
// Bit-serial to WORD_W-bit packer: bit i of the word is the i-th bit shifted in.
module trivium_word_packer #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              shift_en,
    input  logic              pop,
    input  logic              bit_in,
    output logic [WORD_W-1:0] data,
    output logic              last_bit,
    output logic              full
);

    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    logic [IDX_W-1:0] bit_idx;

    assign last_bit = (bit_idx == IDX_W'(WORD_W - 1));

    // Clear wins over shift so an abandoned word never leaves a stale full flag or index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data    <= '0;
            bit_idx <= '0;
            full    <= 1'b0;
        end else if (clear) begin
            bit_idx <= '0;
            full    <= 1'b0;
        end else begin
            if (pop) begin
                full <= 1'b0;
            end
            if (shift_en) begin
                data[bit_idx] <= bit_in;
                if (last_bit) begin
                    bit_idx <= '0;
                    full    <= 1'b1;
                end else begin
                    bit_idx <= bit_idx + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/trivium_stream_ctrl.sv
// Sequencer: load, warm up and drain a Trivium core into WORD_W-bit words.
// Optional abort input enabled by defining TRIVIUM_CTRL_ABORT_EN.
module trivium_stream_ctrl
    import trivium_pkg::*;
#(
    parameter int WORD_W      = 32,
    parameter int LEN_W       = 16,
    parameter int INIT_CYCLES = INIT_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
`ifdef TRIVIUM_CTRL_ABORT_EN
    input  logic              abort,
`endif
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [KEY_W-1:0]  key,
    input  logic [IV_W-1:0]   iv,
    input  logic [LEN_W-1:0]  nwords,
    output logic              core_load,
    output logic [KEY_W-1:0]  core_key,
    output logic [IV_W-1:0]   core_iv,
    output logic              core_step,
    input  logic              core_z,
    output logic              ks_valid,
    input  logic              ks_ready,
    output logic [WORD_W-1:0] ks_data,
    output logic              ks_last,
    output logic              busy,
    output logic              done
);

    localparam int STEP_W = $clog2(INIT_CYCLES + 1);

    ctrl_state_t       state, state_d;
    logic [STEP_W-1:0] step_cnt;
    logic [LEN_W-1:0]  word_cnt;
    logic [LEN_W-1:0]  nwords_q;
    logic              accept;
    logic              abort_now;
    logic              last_word;
    logic              gen_shift;
    logic              hold_pop;
    logic              pk_last;

`ifdef TRIVIUM_CTRL_ABORT_EN
    assign abort_now = abort && (state != ST_IDLE);
`else
    assign abort_now = 1'b0;
`endif

    assign accept    = (state == ST_IDLE) && start_valid;
    assign last_word = (word_cnt == nwords_q - LEN_W'(1));
    assign ks_last   = ks_valid && last_word;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            step_cnt <= '0;
            word_cnt <= '0;
            nwords_q <= '0;
            core_key <= '0;
            core_iv  <= '0;
        end else begin
            state <= state_d;
            if (accept) begin
                core_key <= key;
                core_iv  <= iv;
                nwords_q <= nwords;
                word_cnt <= '0;
            end
            if (state == ST_LOAD) begin
                step_cnt <= '0;
            end else if (state == ST_WARMUP) begin
                step_cnt <= step_cnt + STEP_W'(1);
            end
            if (hold_pop && !abort_now) begin
                word_cnt <= word_cnt + LEN_W'(1);
            end
        end
    end

    // The core only steps in WARMUP and GEN, so a stalled HOLD freezes the stream.
    always_comb begin
        state_d     = state;
        start_ready = 1'b0;
        core_load   = 1'b0;
        core_step   = 1'b0;
        gen_shift   = 1'b0;
        hold_pop    = 1'b0;
        busy        = (state != ST_IDLE);
        done        = 1'b0;
        case (state)
            ST_IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    state_d = (nwords == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                core_load = 1'b1;
                state_d   = ST_WARMUP;
            end
            ST_WARMUP: begin
                core_step = 1'b1;
                if (step_cnt == STEP_W'(INIT_CYCLES - 1)) begin
                    state_d = ST_GEN;
                end
            end
            ST_GEN: begin
                core_step = 1'b1;
                gen_shift = 1'b1;
                if (pk_last) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                hold_pop = ks_ready;
                if (ks_ready) begin
                    state_d = last_word ? ST_DONE : ST_GEN;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort_now) begin
            state_d = ST_IDLE;
        end
    end

    trivium_word_packer #(
        .WORD_W(WORD_W)
    ) u_packer (
        .clk      (clk),
        .reset    (reset),
        .clear    (accept || abort_now),
        .shift_en (gen_shift),
        .pop      (hold_pop),
        .bit_in   (core_z),
        .data     (ks_data),
        .last_bit (pk_last),
        .full     (ks_valid)
    );

endmodule
